uart_rx_deser: RTL

Serial receive front end for the user-project UART. Synchronizes the asynchronous RX pin, detects the start bit, samples 8N1 frames at mid-bit using a clocks-per-bit counter, and presents the byte plus status to the UART control/register block. The control block reads the byte over Wishbone, then pulses `i_rx_finish` to acknowledge it.

---
 rtl/uart_rx_deser.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: synchronizes the RX pin, samples each bit at mid-bit,
// and holds the received byte plus irq/frame-error/overrun status until acknowledged.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx_line,
    input  logic       i_rx_finish,
    output logic [7:0] o_rx_data,
    output logic       o_irq,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_rx_s;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          w_byte_done;
    logic          w_frame_bad;
    logic [7:0]    r_rx_data;
    logic          r_irq;
    logic          r_frame_err;
    logic          r_overrun;

    // Two-flop synchronizer; idle-high reset value avoids a false start bit out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_line;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_byte_done    = 1'b0;
        w_frame_bad    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                    w_cnt_next   = '0;
                end
            end

            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next   = ST_DATA;
                        w_bit_idx_next = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end

            ST_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    w_cnt_next   = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end

            ST_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_byte_done  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end

            // A line held low must recover to idle before another frame can start.
            ST_BREAK: begin
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Status flags: a new event at the same edge as the acknowledge takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data   <= '0;
            r_irq       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_byte_done) begin
                r_rx_data <= r_shift;
            end

            if (w_byte_done) begin
                r_irq <= 1'b1;
            end else if (i_rx_finish) begin
                r_irq <= 1'b0;
            end

            if (w_byte_done && r_irq) begin
                r_overrun <= 1'b1;
            end else if (i_rx_finish) begin
                r_overrun <= 1'b0;
            end

            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end else if (i_rx_finish) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_irq       = r_irq;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != ST_IDLE);

endmodule
